// File: rtl/simd_shift_unit.sv
// Iterative SIMD shifter: 1/2/4 lanes, LSL/LSR/ASR/ROR, one bit per cycle within each lane.
// DONE pulses N+2 cycles after accept (N = AMT mod lane width); START is ignored while BUSY.
module simd_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [AMT_W-1:0] AMT,
  input  logic [1:0]       OP,
  input  logic [1:0]       LANE_MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] lsb_mask;
  logic [WIDTH-1:0] msb_mask;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [1:0]       mode_q;
  logic             accept;
  logic             step;
  logic             finish;

  function automatic int lane_width(input logic [1:0] mode);
    case (mode)
      2'b01:   return WIDTH / 2;
      2'b10:   return WIDTH / 4;
      default: return WIDTH;
    endcase
  endfunction

  function automatic logic [AMT_W-1:0] amt_mask(input logic [1:0] mode);
    case (mode)
      2'b01:   return AMT_W'(WIDTH / 2 - 1);
      2'b10:   return AMT_W'(WIDTH / 4 - 1);
      default: return AMT_W'(WIDTH - 1);
    endcase
  endfunction

  // One set bit at the least significant position of every lane.
  function automatic logic [WIDTH-1:0] lane_lsb_mask(input logic [1:0] mode);
    logic [WIDTH-1:0] m;
    int               lw;
    lw = lane_width(mode);
    m  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = ((i % lw) == 0);
    end
    return m;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt != '0) begin
          step = 1'b1;
        end else begin
          finish   = 1'b1;
          state_nx = FIN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign BUSY = (state == RUN) || (state == FIN);
  assign DONE = (state == FIN);

  // Lane MSB mask is the LSB mask rotated down one bit: each lane base lands
  // on the top bit of the lane below it.
  always_comb begin
    lsb_mask = lane_lsb_mask(mode_q);
    msb_mask = {lsb_mask[0], lsb_mask[WIDTH-1:1]};
    shifted  = '0;
    case (op_q)
      OP_LSL:  shifted = (work << 1) & ~lsb_mask;
      OP_LSR:  shifted = (work >> 1) & ~msb_mask;
      OP_ASR:  shifted = ((work >> 1) & ~msb_mask) | (work & msb_mask);
      default: shifted = ((work >> 1) & ~msb_mask)
                         | ((work & lsb_mask) << (lane_width(mode_q) - 1));
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      mode_q <= '0;
      RESULT <= '0;
    end else if (accept) begin
      work   <= DATA_IN;
      op_q   <= OP;
      mode_q <= LANE_MODE;
      cnt    <= AMT & amt_mask(LANE_MODE);
    end else if (step) begin
      work <= shifted;
      cnt  <= cnt - AMT_W'(1);
    end else if (finish) begin
      RESULT <= work;
    end
  end

endmodule

// File: tb/tb_simd_shift_unit.sv
// Directed bench for simd_shift_unit at WIDTH=32 with hand-computed results and latencies.
module tb_simd_shift_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [31:0] DATA_IN;
  logic [4:0]  AMT;
  logic [1:0]  OP;
  logic [1:0]  LANE_MODE;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int d0;

  simd_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .DATA_IN   (DATA_IN),
    .AMT       (AMT),
    .OP        (OP),
    .LANE_MODE (LANE_MODE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble inputs afterwards, then check latency and result.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [1:0] op,
                        input logic [4:0] amt, input logic [31:0] data,
                        input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    @(negedge CLK);
    LANE_MODE = mode;
    OP        = op;
    AMT       = amt;
    DATA_IN   = data;
    START     = 1'b1;
    @(posedge CLK);
    #1;
    START     = 1'b0;
    DATA_IN   = $urandom;
    AMT       = 5'($urandom);
    OP        = 2'($urandom);
    LANE_MODE = 2'($urandom);
    cyc = 1;
    check({tag, "_busy1"}, 32'(BUSY), 32'd1);
    while (DONE !== 1'b1 && cyc < 200) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_result"}, RESULT, exp_res);
    @(posedge CLK);
    #1;
    check({tag, "_idle"}, {30'd0, BUSY, DONE}, 32'd0);
  endtask

  initial begin
    RESET     = 1'b1;
    START     = 1'b0;
    DATA_IN   = '0;
    AMT       = '0;
    OP        = '0;
    LANE_MODE = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_result", RESULT, 32'd0);
    RESET = 1'b0;

    run_op("lsl_full",   2'b00, 2'b00, 5'd4,  32'h0000_00F1, 32'h0000_0F10, 6);
    run_op("asr_full31", 2'b00, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    run_op("ror_2lane",  2'b01, 2'b11, 5'd4,  32'h1234_ABCD, 32'h4123_DABC, 6);
    run_op("asr_4lane",  2'b10, 2'b10, 5'd9,  32'h807F_FE01, 32'hC03F_FF00, 3);
    run_op("lsr_4lane",  2'b10, 2'b01, 5'd3,  32'hFF80_0108, 32'h1F10_0001, 5);
    run_op("lsr_mode11", 2'b11, 2'b01, 5'd8,  32'h1234_5678, 32'h0012_3456, 10);
    run_op("lsl_2lane",  2'b01, 2'b00, 5'd17, 32'h8001_4001, 32'h0002_8002, 3);
    run_op("ror_full",   2'b00, 2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000, 3);
    run_op("asr_2lane",  2'b01, 2'b10, 5'd2,  32'h8000_7FFC, 32'hE000_1FFF, 4);

    // AMT=0 with START held through RUN and FIN: exactly one operation.
    d0 = done_cnt;
    @(negedge CLK);
    LANE_MODE = 2'b00;
    OP        = 2'b00;
    AMT       = 5'd0;
    DATA_IN   = 32'hDEAD_BEEF;
    START     = 1'b1;
    @(posedge CLK);
    #1;
    DATA_IN = 32'h0000_0001;
    check("amt0_busy1", 32'(BUSY), 32'd1);
    @(posedge CLK);
    #1;
    check("amt0_done_c2", 32'(DONE), 32'd1);
    check("amt0_result", RESULT, 32'hDEAD_BEEF);
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("amt0_fin_start_ignored", {30'd0, BUSY, DONE}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("amt0_one_done", 32'(done_cnt - d0), 32'd1);
    check("amt0_result_held", RESULT, 32'hDEAD_BEEF);

    // Abort a long operation with RESET, then restart immediately.
    @(negedge CLK);
    AMT     = 5'd20;
    DATA_IN = 32'h0000_0001;
    START   = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("abort_running", 32'(BUSY), 32'd1);
    d0 = done_cnt;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_result", RESULT, 32'd0);
    RESET = 1'b0;
    run_op("post_reset", 2'b00, 2'b00, 5'd1, 32'h0000_0001, 32'h0000_0002, 3);
    check("abort_no_done", 32'(done_cnt - d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
